sqa_pipe: RTL and testbench

SQA_PIPE -- requirements
Module: sqa_pipe

---
 rtl/sqa_pipe_if.sv | 41 ++++
 rtl/sqa_pipe.sv | 112 +++++++++++
 tb/tb_sqa_pipe.sv | 318 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sqa_pipe_if.sv
// rtl/sqa_pipe_if.sv - stream handshake bundle for the sqa_pipe variance pipeline
//
// Purpose: groups the upstream beat (stan_dev_in/avg_in/valid_in/ready_out) and
// the downstream beat (var_out/avg_out/valid_out/ready_in/last_out/ovf_out).
// Ports (lane i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]):
//   stan_dev_in  CHANNELS*DATA_WIDTH  signed standard deviation samples
//   avg_in       CHANNELS*DATA_WIDTH  signed mean, passed through
//   valid_in     1                    upstream beat valid
//   ready_out    1                    pipeline can accept a beat
//   var_out      CHANNELS*DATA_WIDTH  signed variance
//   avg_out      CHANNELS*DATA_WIDTH  mean aligned with var_out
//   valid_out    1                    output beat valid
//   ready_in     1                    downstream accepts beat
//   last_out     1                    final beat of a mini batch
//   ovf_out      CHANNELS             per-lane saturation flag
// modport slave is the pipeline side, modport master the producer/consumer side.
interface sqa_pipe_if #(
   parameter int DATA_WIDTH = 16,
   parameter int CHANNELS   = 4
);
   logic [CHANNELS*DATA_WIDTH-1:0] stan_dev_in;
   logic [CHANNELS*DATA_WIDTH-1:0] avg_in;
   logic                           valid_in;
   logic                           ready_out;
   logic [CHANNELS*DATA_WIDTH-1:0] var_out;
   logic [CHANNELS*DATA_WIDTH-1:0] avg_out;
   logic                           valid_out;
   logic                           ready_in;
   logic                           last_out;
   logic [CHANNELS-1:0]            ovf_out;

   modport slave (
      input  stan_dev_in, avg_in, valid_in, ready_in,
      output ready_out, var_out, avg_out, valid_out, last_out, ovf_out
   );

   modport master (
      output stan_dev_in, avg_in, valid_in, ready_in,
      input  ready_out, var_out, avg_out, valid_out, last_out, ovf_out
   );
endinterface

// File: rtl/sqa_pipe.sv
// rtl/sqa_pipe.sv - two-stage squaring pipeline turning standard deviation into variance
//
// Purpose: per lane var = round_half_up(s*s >> FRAC_BITS); avg rides alongside.
// S1 registers the full-width products, S2 the rounded results. Both stages
// advance together on en = !S2_valid || ready_in, so a stalled output freezes
// the whole pipe and ready_out drops only when S2 is occupied and blocked.
// A batch counter tags every MINI_BATCH-th output beat with last_out.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  sqa_pipe_if.slave handshake bundle (see rtl/sqa_pipe_if.sv)
// Configuration macro: SQA_PIPE_SAT_EN - saturate lane results above the
// signed maximum and flag ovf_out; when undefined results wrap and ovf_out is 0.
module sqa_pipe #(
   parameter  int DATA_WIDTH = 16,
   parameter  int CHANNELS   = 4,
   parameter  int FRAC_BITS  = 8,
   parameter  int MINI_BATCH = 64,
   localparam int ADDR_WIDTH = $clog2(MINI_BATCH)
) (
   input  logic      clk,
   input  logic      rst,
   sqa_pipe_if.slave bus
);
   localparam int PW = 2 * DATA_WIDTH;
   // half-LSB of the output format, zero when there is no fraction to drop
   localparam logic [PW:0] RND = (FRAC_BITS == 0) ? '0 :
                                 ((PW+1)'(1) << ((FRAC_BITS > 0) ? FRAC_BITS - 1 : 0));
`ifdef SQA_PIPE_SAT_EN
   localparam logic [PW:0]           MAXV    = (PW+1)'((64'd1 << (DATA_WIDTH - 1)) - 64'd1);
   localparam logic [DATA_WIDTH-1:0] MAX_RES = {1'b0, {(DATA_WIDTH-1){1'b1}}};
`endif

   logic                           w_en;
   logic                           w_xfer_out;
   logic                           w_last;
   logic [CHANNELS*PW-1:0]         w_prod;
   logic [CHANNELS*DATA_WIDTH-1:0] w_res;
   logic [CHANNELS-1:0]            w_ovf;

   logic                           r_s1_valid;
   logic [CHANNELS*PW-1:0]         r_s1_prod;
   logic [CHANNELS*DATA_WIDTH-1:0] r_s1_avg;
   logic                           r_s2_valid;
   logic [CHANNELS*DATA_WIDTH-1:0] r_s2_var;
   logic [CHANNELS*DATA_WIDTH-1:0] r_s2_avg;
   logic [CHANNELS-1:0]            r_s2_ovf;
   logic [ADDR_WIDTH-1:0]          r_cnt;

   for (genvar g = 0; g < CHANNELS; g++) begin : g_lane
      logic signed [PW-1:0] w_sx;
      logic [PW:0]          w_sum;

      // sign-extend before squaring; the square of any DATA_WIDTH signed value
      // fits in PW bits and is never negative, so the low PW bits are exact
      assign w_sx = PW'($signed(bus.stan_dev_in[g*DATA_WIDTH +: DATA_WIDTH]));
      assign w_prod[g*PW +: PW] = w_sx * w_sx;

      // one spare bit keeps the rounding add from carrying out
      assign w_sum = {1'b0, r_s1_prod[g*PW +: PW]} + RND;
`ifdef SQA_PIPE_SAT_EN
      logic [PW:0] w_r;
      assign w_r      = w_sum >> FRAC_BITS;
      assign w_ovf[g] = (w_r > MAXV);
      assign w_res[g*DATA_WIDTH +: DATA_WIDTH] = w_ovf[g] ? MAX_RES : w_r[DATA_WIDTH-1:0];
`else
      assign w_ovf[g] = 1'b0;
      assign w_res[g*DATA_WIDTH +: DATA_WIDTH] = DATA_WIDTH'(w_sum >> FRAC_BITS);
`endif
   end

   assign w_en       = !r_s2_valid || bus.ready_in;
   assign w_xfer_out = r_s2_valid && bus.ready_in;
   assign w_last     = r_s2_valid && (r_cnt == ADDR_WIDTH'(MINI_BATCH - 1));

   assign bus.ready_out = w_en;
   assign bus.valid_out = r_s2_valid;
   assign bus.last_out  = w_last;
   assign bus.var_out   = r_s2_valid ? r_s2_var : '0;
   assign bus.avg_out   = r_s2_valid ? r_s2_avg : '0;
   assign bus.ovf_out   = r_s2_valid ? r_s2_ovf : '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_s1_valid <= 1'b0;
         r_s1_prod  <= '0;
         r_s1_avg   <= '0;
         r_s2_valid <= 1'b0;
         r_s2_var   <= '0;
         r_s2_avg   <= '0;
         r_s2_ovf   <= '0;
         r_cnt      <= '0;
      end else begin
         if (w_en) begin
            r_s1_valid <= bus.valid_in;
            if (bus.valid_in) begin
               r_s1_prod <= w_prod;
               r_s1_avg  <= bus.avg_in;
            end
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
               r_s2_var <= w_res;
               r_s2_avg <= r_s1_avg;
               r_s2_ovf <= w_ovf;
            end
         end
         if (w_xfer_out) begin
            r_cnt <= w_last ? '0 : r_cnt + 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_sqa_pipe.sv
// tb/tb_sqa_pipe.sv - randomized self-checking bench for sqa_pipe
module tb_sqa_pipe;
   localparam int DW = 16;
   localparam int CH = 4;
   localparam int FB = 8;
   localparam int MB = 64;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   sqa_pipe_if #(.DATA_WIDTH(DW), .CHANNELS(CH)) bus ();

   sqa_pipe #(.DATA_WIDTH(DW), .CHANNELS(CH), .FRAC_BITS(FB), .MINI_BATCH(MB)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic [CH*DW-1:0] v;
      logic [CH*DW-1:0] a;
      logic [CH-1:0]    o;
   } beat_t;

   int    total = 0;
   int    bad   = 0;
   beat_t exp_q[$];
   int    m_cnt = 0;

   // variance from the arithmetic definition: square, add half, floor divide
   function automatic beat_t ref_beat(input logic [CH*DW-1:0] s, input logic [CH*DW-1:0] a);
      beat_t b;
      b.a = a;
      b.v = '0;
      b.o = '0;
      for (int i = 0; i < CH; i++) begin
         longint sv;
         longint r;
         sv = longint'($signed(s[i*DW +: DW]));
         r  = (sv * sv + (longint'(1) << (FB - 1))) / (longint'(1) << FB);
`ifdef SQA_PIPE_SAT_EN
         if (r > 32767) begin
            b.v[i*DW +: DW] = 16'h7FFF;
            b.o[i]          = 1'b1;
         end else begin
            b.v[i*DW +: DW] = 16'(r);
         end
`else
         b.v[i*DW +: DW] = 16'(r);
`endif
      end
      return b;
   endfunction

   function automatic logic [CH*DW-1:0] rnd_vec();
      logic [CH*DW-1:0] x;
      for (int i = 0; i < CH; i++) begin
         case ($urandom_range(0, 7))
            0:       x[i*DW +: DW] = 16'h7FFF;
            1:       x[i*DW +: DW] = 16'h8000;
            2:       x[i*DW +: DW] = 16'h0000;
            default: x[i*DW +: DW] = 16'($urandom);
         endcase
      end
      return x;
   endfunction

   task automatic drive(input logic v, input logic rdy, input logic [CH*DW-1:0] s,
                        input logic [CH*DW-1:0] a);
      @(negedge clk);
      bus.valid_in    = v;
      bus.ready_in    = rdy;
      bus.stan_dev_in = s;
      bus.avg_in      = a;
      #1;
   endtask

   // model bookkeeping for this cycle's handshakes (no checking here)
   task automatic account();
      if (bus.valid_out === 1'b1 && bus.ready_in) begin
         if (exp_q.size() > 0) void'(exp_q.pop_front());
         m_cnt = (m_cnt == MB - 1) ? 0 : m_cnt + 1;
      end
      if (bus.valid_in && bus.ready_out === 1'b1)
         exp_q.push_back(ref_beat(bus.stan_dev_in, bus.avg_in));
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst          = 1'b1;
      bus.valid_in = 1'b0;
      bus.ready_in = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      exp_q.delete();
      m_cnt = 0;
   endtask

   task automatic test_reset();
      do_reset();
      total++;
      if (bus.ready_out !== 1'b1) begin
         bad++; $display("FAIL reset_ready: got %b want 1", bus.ready_out);
      end
      total++;
      if ({bus.valid_out, bus.last_out, bus.ovf_out} !== '0) begin
         bad++; $display("FAIL reset_flags: valid/last/ovf got %b%b%b want 0", bus.valid_out, bus.last_out, bus.ovf_out);
      end
      total++;
      if ({bus.var_out, bus.avg_out} !== '0) begin
         bad++; $display("FAIL reset_data: var %h avg %h want 0", bus.var_out, bus.avg_out);
      end
      rst = 1'b0;
   endtask

   task automatic test_directed();
      logic [CH*DW-1:0] exp_v;
      logic [CH-1:0]    exp_o;
`ifdef SQA_PIPE_SAT_EN
      exp_v = {16'h7FFF, 16'h0000, 16'h0240, 16'h0100};
      exp_o = 4'b1000;
`else
      exp_v = {16'hFF00, 16'h0000, 16'h0240, 16'h0100};
      exp_o = 4'b0000;
`endif
      drive(1'b1, 1'b1, {16'h7FFF, 16'h0001, 16'hFE80, 16'h0100}, {16'h0004, 16'h0003, 16'h0002, 16'h0123});
      total++;
      if (bus.ready_out !== 1'b1) begin
         bad++; $display("FAIL dir_accept: ready_out %b want 1", bus.ready_out);
      end
      drive(1'b0, 1'b1, '0, '0);
      total++;
      if (bus.valid_out !== 1'b0) begin
         bad++; $display("FAIL dir_latency1: valid_out %b want 0", bus.valid_out);
      end
      drive(1'b0, 1'b1, '0, '0);
      total++;
      if (bus.valid_out !== 1'b1) begin
         bad++; $display("FAIL dir_latency2: valid_out %b want 1", bus.valid_out);
      end
      total++;
      if (bus.var_out !== exp_v) begin
         bad++; $display("FAIL dir_var: got %h want %h", bus.var_out, exp_v);
      end
      total++;
      if (bus.avg_out[DW-1:0] !== 16'h0123) begin
         bad++; $display("FAIL dir_avg: got %h want 0123", bus.avg_out[DW-1:0]);
      end
      total++;
      if (bus.ovf_out !== exp_o) begin
         bad++; $display("FAIL dir_ovf: got %b want %b", bus.ovf_out, exp_o);
      end
      drive(1'b0, 1'b1, '0, '0);
      total++;
      if (bus.valid_out !== 1'b0) begin
         bad++; $display("FAIL dir_drain: valid_out %b want 0", bus.valid_out);
      end
   endtask

   task automatic test_stall();
      logic [CH*DW-1:0] s[3];
      logic [CH*DW-1:0] a[3];
      int idx = 0;
      int got = 0;
      do_reset();
      rst = 1'b0;
      for (int k = 0; k < 3; k++) begin
         s[k] = rnd_vec();
         a[k] = rnd_vec();
      end
      for (int c = 0; c < 8; c++) begin
         drive(idx < 3, 1'b0, s[idx % 3], a[idx % 3]);
         if (c >= 2) begin
            total++;
            if (bus.ready_out !== 1'b0) begin
               bad++; $display("FAIL stall_ready cyc %0d: got %b want 0", c, bus.ready_out);
            end
            total++;
            if (bus.valid_out !== 1'b1 || exp_q.size() == 0 ||
                {bus.var_out, bus.avg_out, bus.ovf_out} !== {exp_q[0].v, exp_q[0].a, exp_q[0].o}) begin
               bad++; $display("FAIL stall_hold cyc %0d: valid %b var %h avg %h", c, bus.valid_out, bus.var_out, bus.avg_out);
            end
         end
         if (bus.valid_in && bus.ready_out === 1'b1) idx++;
         account();
      end
      for (int c = 0; c < 20 && got < 3; c++) begin
         drive(idx < 3, 1'b1, s[idx % 3], a[idx % 3]);
         if (bus.valid_out === 1'b1) begin
            got++;
            total++;
            if (exp_q.size() == 0 ||
                {bus.var_out, bus.avg_out, bus.ovf_out} !== {exp_q[0].v, exp_q[0].a, exp_q[0].o}) begin
               bad++; $display("FAIL stall_order beat %0d: var %h avg %h", got, bus.var_out, bus.avg_out);
            end
         end
         if (bus.valid_in && bus.ready_out === 1'b1) idx++;
         account();
      end
      total++;
      if (got != 3 || idx != 3) begin
         bad++; $display("FAIL stall_count: got %0d beats %0d accepted want 3 3", got, idx);
      end
   endtask

   task automatic test_random_stream();
      do_reset();
      rst = 1'b0;
      for (int c = 0; c < 420; c++) begin
         drive((c < 400) && ($urandom_range(0, 3) != 0), (c >= 400) || ($urandom_range(0, 2) != 0),
               rnd_vec(), rnd_vec());
         total++;
         if (bus.ready_out !== (!bus.valid_out || bus.ready_in)) begin
            bad++; $display("FAIL rand_ready cyc %0d: got %b want %b", c, bus.ready_out, !bus.valid_out || bus.ready_in);
         end
         total++;
         if (bus.valid_out === 1'b1) begin
            if (exp_q.size() == 0) begin
               bad++; $display("FAIL rand_spurious cyc %0d: valid_out with no beat expected", c);
            end else if ({bus.var_out, bus.avg_out, bus.ovf_out, bus.last_out} !==
                         {exp_q[0].v, exp_q[0].a, exp_q[0].o, (m_cnt == MB - 1)}) begin
               bad++; $display("FAIL rand_beat cyc %0d: var %h avg %h ovf %b last %b want %h %h %b %b", c,
                               bus.var_out, bus.avg_out, bus.ovf_out, bus.last_out,
                               exp_q[0].v, exp_q[0].a, exp_q[0].o, (m_cnt == MB - 1));
            end
         end else if ({bus.var_out, bus.avg_out, bus.ovf_out, bus.last_out} !== '0) begin
            bad++; $display("FAIL rand_idle cyc %0d: outputs not zero var %h avg %h", c, bus.var_out, bus.avg_out);
         end
         account();
      end
      total++;
      if (exp_q.size() != 0) begin
         bad++; $display("FAIL rand_drain: %0d beats missing want 0", exp_q.size());
      end
   endtask

   task automatic test_batch();
      int n_out = 0;
      do_reset();
      rst = 1'b0;
      for (int c = 0; c < 140 && n_out < 128; c++) begin
         drive(c < 128, 1'b1, rnd_vec(), rnd_vec());
         if (c >= 2 && c < 130) begin
            total++;
            if (bus.valid_out !== 1'b1) begin
               bad++; $display("FAIL batch_tput cyc %0d: valid_out %b want 1", c, bus.valid_out);
            end
         end
         if (bus.valid_out === 1'b1) begin
            total++;
            if (exp_q.size() == 0 || bus.last_out !== ((n_out % MB) == MB - 1) || bus.var_out !== exp_q[0].v) begin
               bad++; $display("FAIL batch_last beat %0d: last %b want %b", n_out + 1, bus.last_out, (n_out % MB) == MB - 1);
            end
            n_out++;
         end
         account();
      end
      total++;
      if (n_out != 128) begin
         bad++; $display("FAIL batch_count: got %0d want 128", n_out);
      end
   endtask

   task automatic test_reset_midstream();
      int n_out = 0;
      do_reset();
      rst = 1'b0;
      for (int c = 0; c < 30 && n_out < 10; c++) begin
         drive(1'b1, 1'b1, rnd_vec(), rnd_vec());
         if (bus.valid_out === 1'b1) n_out++;
         account();
      end
      @(negedge clk);
      rst          = 1'b1;
      bus.valid_in = 1'b0;
      @(negedge clk);
      #1;
      total++;
      if ({bus.valid_out, bus.last_out, bus.ready_out} !== 3'b001) begin
         bad++; $display("FAIL mid_reset: valid/last/ready got %b%b%b want 001", bus.valid_out, bus.last_out, bus.ready_out);
      end
      rst = 1'b0;
      exp_q.delete();
      m_cnt = 0;
      n_out = 0;
      for (int c = 0; c < 80 && n_out < 66; c++) begin
         drive(1'b1, 1'b1, rnd_vec(), rnd_vec());
         if (bus.valid_out === 1'b1) begin
            total++;
            if (exp_q.size() == 0 || bus.last_out !== (n_out == MB - 1) || bus.avg_out !== exp_q[0].a) begin
               bad++; $display("FAIL mid_last beat %0d: last %b want %b", n_out + 1, bus.last_out, n_out == MB - 1);
            end
            n_out++;
         end
         account();
      end
      total++;
      if (n_out != 66) begin
         bad++; $display("FAIL mid_count: got %0d want 66", n_out);
      end
   endtask

   initial begin
      bus.valid_in    = 1'b0;
      bus.ready_in    = 1'b0;
      bus.stan_dev_in = '0;
      bus.avg_in      = '0;
      test_reset();
      test_directed();
      test_stall();
      test_random_stream();
      test_batch();
      test_reset_midstream();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
